// File: rtl/sweep_ctrl.sv
// Frequency-sweep controller: steps the DDS phase increment from START_FREQ to STOP_FREQ,
// holding each value DWELL_CYCLES clocks, in linear, sawtooth or triangle profiles.
module sweep_ctrl #(
   parameter logic [31:0] START_FREQ   = 32'h0000,
   parameter logic [31:0] STOP_FREQ    = 32'hFFFF,
   parameter logic [31:0] STEP         = 32'h0100,
   parameter int unsigned DWELL_CYCLES = 50_000,
   parameter string       MOD          = "linear",
   parameter logic [15:0] PHASE_OFFSET = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic        i_stop,
   output logic [15:0] o_pinc,
   output logic [15:0] o_poff,
   output logic        o_cfg_valid,
   output logic        o_running,
   output logic        o_done
);

   localparam logic [15:0] START16  = START_FREQ[15:0];
   localparam logic [15:0] STOP16   = STOP_FREQ[15:0];
   localparam logic [15:0] STEP16   = STEP[15:0];
   localparam logic [31:0] DWELL_M1 = DWELL_CYCLES - 1;
   localparam bit          IS_SAW   = (MOD == "saw");
   localparam bit          IS_TRI   = (MOD == "triangle");

   typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

   state_t      state;
   logic [31:0] dwell_cnt;
   logic        dir_down;

   logic [16:0] up_sum;
   logic [16:0] down_floor;
   logic [15:0] up_next;
   logic [15:0] down_next;
   logic        at_stop;
   logic        at_start;
   logic [15:0] load_val;
   logic        load_down;
   logic        linear_end;

   assign o_poff = PHASE_OFFSET;

   // 17-bit sums keep the clamp and floor comparisons free of 16-bit wrap.
   always_comb begin
      up_sum     = {1'b0, o_pinc} + {1'b0, STEP16};
      up_next    = (up_sum > {1'b0, STOP16}) ? STOP16 : up_sum[15:0];
      down_floor = {1'b0, START16} + {1'b0, STEP16};
      down_next  = ({1'b0, o_pinc} < down_floor) ? START16 : (o_pinc - STEP16);
      at_stop    = (o_pinc == STOP16);
      at_start   = (o_pinc == START16);
      linear_end = !dir_down && at_stop && !IS_SAW && !IS_TRI;
      load_val   = up_next;
      load_down  = 1'b0;
      if (!dir_down && at_stop) begin
         load_val  = IS_TRI ? down_next : START16;
         load_down = IS_TRI;
      end else if (dir_down && !at_start) begin
         load_val  = down_next;
         load_down = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         o_pinc      <= START16;
         o_cfg_valid <= 1'b0;
         o_running   <= 1'b0;
         o_done      <= 1'b0;
         dwell_cnt   <= '0;
         dir_down    <= 1'b0;
      end else begin
         o_cfg_valid <= 1'b0;
         o_done      <= 1'b0;
         if (i_stop && state != IDLE) begin
            state     <= IDLE;
            o_running <= 1'b0;
         end else if (i_start && !i_stop) begin
            state       <= DWELL;
            o_pinc      <= START16;
            o_cfg_valid <= 1'b1;
            o_running   <= 1'b1;
            dwell_cnt   <= DWELL_M1;
            dir_down    <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               DWELL: begin
                  if (dwell_cnt != '0) begin
                     dwell_cnt <= dwell_cnt - 1;
                  end else if (linear_end) begin
                     state     <= DONE;
                     o_running <= 1'b0;
                     o_done    <= 1'b1;
                  end else begin
                     o_pinc      <= load_val;
                     o_cfg_valid <= 1'b1;
                     dwell_cnt   <= DWELL_M1;
                     dir_down    <= load_down;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl: several parameterisations driven side by side
// on one clock, each checked against hand-computed sweep sequences.
module tb_sweep_ctrl;

   logic        clk;
   logic        rst;
   logic        start_v [7];
   logic        stop_v  [7];
   logic [15:0] pinc    [7];
   logic [15:0] poff    [7];
   logic        cfg     [7];
   logic        run     [7];
   logic        done    [7];

   int ntests = 0;
   int nfail  = 0;

   logic [15:0] tri_exp [8] = '{16'h1000, 16'h1100, 16'h1200, 16'h1300,
                                16'h1200, 16'h1100, 16'h1000, 16'h1100};
   logic [15:0] saw_exp [8] = '{16'h1000, 16'h1100, 16'h1200, 16'h1300,
                                16'h1000, 16'h1100, 16'h1200, 16'h1300};

   // 0 linear, 1 clamp, 2 triangle, 3 saw, 4 dwell=1, 5 start==stop, 6 full range
   sweep_ctrl #(.START_FREQ(32'h1000), .STOP_FREQ(32'h1300), .STEP(32'h100), .DWELL_CYCLES(4),
                .MOD("linear"), .PHASE_OFFSET(16'h1234)) u_lin (
      .clk(clk), .rst(rst), .i_start(start_v[0]), .i_stop(stop_v[0]), .o_pinc(pinc[0]),
      .o_poff(poff[0]), .o_cfg_valid(cfg[0]), .o_running(run[0]), .o_done(done[0]));
   sweep_ctrl #(.START_FREQ(32'h1000), .STOP_FREQ(32'h1250), .STEP(32'h100), .DWELL_CYCLES(4),
                .MOD("linear"), .PHASE_OFFSET(16'h0000)) u_clamp (
      .clk(clk), .rst(rst), .i_start(start_v[1]), .i_stop(stop_v[1]), .o_pinc(pinc[1]),
      .o_poff(poff[1]), .o_cfg_valid(cfg[1]), .o_running(run[1]), .o_done(done[1]));
   sweep_ctrl #(.START_FREQ(32'h1000), .STOP_FREQ(32'h1300), .STEP(32'h100), .DWELL_CYCLES(4),
                .MOD("triangle"), .PHASE_OFFSET(16'h0000)) u_tri (
      .clk(clk), .rst(rst), .i_start(start_v[2]), .i_stop(stop_v[2]), .o_pinc(pinc[2]),
      .o_poff(poff[2]), .o_cfg_valid(cfg[2]), .o_running(run[2]), .o_done(done[2]));
   sweep_ctrl #(.START_FREQ(32'h1000), .STOP_FREQ(32'h1300), .STEP(32'h100), .DWELL_CYCLES(4),
                .MOD("saw"), .PHASE_OFFSET(16'h0000)) u_saw (
      .clk(clk), .rst(rst), .i_start(start_v[3]), .i_stop(stop_v[3]), .o_pinc(pinc[3]),
      .o_poff(poff[3]), .o_cfg_valid(cfg[3]), .o_running(run[3]), .o_done(done[3]));
   sweep_ctrl #(.START_FREQ(32'h1000), .STOP_FREQ(32'h1300), .STEP(32'h100), .DWELL_CYCLES(1),
                .MOD("linear"), .PHASE_OFFSET(16'h0000)) u_d1 (
      .clk(clk), .rst(rst), .i_start(start_v[4]), .i_stop(stop_v[4]), .o_pinc(pinc[4]),
      .o_poff(poff[4]), .o_cfg_valid(cfg[4]), .o_running(run[4]), .o_done(done[4]));
   sweep_ctrl #(.START_FREQ(32'h1000), .STOP_FREQ(32'h1000), .STEP(32'h100), .DWELL_CYCLES(4),
                .MOD("linear"), .PHASE_OFFSET(16'h0000)) u_eq (
      .clk(clk), .rst(rst), .i_start(start_v[5]), .i_stop(stop_v[5]), .o_pinc(pinc[5]),
      .o_poff(poff[5]), .o_cfg_valid(cfg[5]), .o_running(run[5]), .o_done(done[5]));
   sweep_ctrl #(.START_FREQ(32'h0000), .STOP_FREQ(32'hFFFF), .STEP(32'h8000), .DWELL_CYCLES(2),
                .MOD("linear"), .PHASE_OFFSET(16'h0000)) u_big (
      .clk(clk), .rst(rst), .i_start(start_v[6]), .i_stop(stop_v[6]), .o_pinc(pinc[6]),
      .o_poff(poff[6]), .o_cfg_valid(cfg[6]), .o_running(run[6]), .o_done(done[6]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          strobes;
      logic [15:0] e_lin, e_clamp, e_d1, e_big;

      rst = 1'b1;
      for (int i = 0; i < 7; i++) begin
         start_v[i] = 1'b0;
         stop_v[i]  = 1'b0;
      end
      #2;
      chk("rst_pinc", pinc[0], 16'h1000);
      chk("rst_poff", poff[0], 16'h1234);
      chk("rst_cfg", cfg[0], 1'b0);
      chk("rst_run", run[0], 1'b0);
      chk("rst_done", done[0], 1'b0);
      chk("rst_pinc_big", pinc[6], 16'h0000);
      step();
      step();
      rst = 1'b0;
      step();
      step();
      chk("idle_run", run[0], 1'b0);
      chk("idle_cfg", cfg[0], 1'b0);

      // Linear, clamp, dwell=1, start==stop and full-range sweeps launched together.
      start_v[0] = 1'b1; start_v[1] = 1'b1; start_v[4] = 1'b1;
      start_v[5] = 1'b1; start_v[6] = 1'b1;
      step();
      start_v[0] = 1'b0; start_v[1] = 1'b0; start_v[4] = 1'b0;
      start_v[5] = 1'b0; start_v[6] = 1'b0;
      strobes = 0;
      for (int c = 1; c <= 18; c++) begin
         e_lin   = (c <= 4) ? 16'h1000 : (c <= 8) ? 16'h1100 : (c <= 12) ? 16'h1200 : 16'h1300;
         e_clamp = (c <= 12) ? e_lin : 16'h1250;
         e_d1    = (c == 1) ? 16'h1000 : (c == 2) ? 16'h1100 : (c == 3) ? 16'h1200 : 16'h1300;
         e_big   = (c <= 2) ? 16'h0000 : (c <= 4) ? 16'h8000 : 16'hFFFF;
         if (cfg[0] === 1'b1) strobes++;
         chk($sformatf("lin_pinc@%0d", c), pinc[0], e_lin);
         chk($sformatf("lin_cfg@%0d", c), cfg[0], (c <= 13) && ((c - 1) % 4 == 0));
         chk($sformatf("lin_run@%0d", c), run[0], c <= 16);
         chk($sformatf("lin_done@%0d", c), done[0], c == 17);
         chk($sformatf("lin_poff@%0d", c), poff[0], 16'h1234);
         chk($sformatf("clamp_pinc@%0d", c), pinc[1], e_clamp);
         chk($sformatf("clamp_done@%0d", c), done[1], c == 17);
         chk($sformatf("d1_pinc@%0d", c), pinc[4], e_d1);
         chk($sformatf("d1_cfg@%0d", c), cfg[4], c <= 4);
         chk($sformatf("d1_done@%0d", c), done[4], c == 5);
         chk($sformatf("eq_pinc@%0d", c), pinc[5], 16'h1000);
         chk($sformatf("eq_cfg@%0d", c), cfg[5], c == 1);
         chk($sformatf("eq_run@%0d", c), run[5], c <= 4);
         chk($sformatf("eq_done@%0d", c), done[5], c == 5);
         chk($sformatf("big_pinc@%0d", c), pinc[6], e_big);
         chk($sformatf("big_cfg@%0d", c), cfg[6], (c == 1) || (c == 3) || (c == 5));
         chk($sformatf("big_done@%0d", c), done[6], c == 7);
         step();
      end
      chk("lin_strobes", strobes, 4);

      // Triangle and saw profiles.
      start_v[2] = 1'b1; start_v[3] = 1'b1;
      step();
      start_v[2] = 1'b0; start_v[3] = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         chk($sformatf("tri_pinc@%0d", c), pinc[2], tri_exp[(c - 1) / 4]);
         chk($sformatf("tri_cfg@%0d", c), cfg[2], (c - 1) % 4 == 0);
         chk($sformatf("tri_run@%0d", c), run[2], 1'b1);
         chk($sformatf("saw_pinc@%0d", c), pinc[3], saw_exp[(c - 1) / 4]);
         chk($sformatf("saw_cfg@%0d", c), cfg[3], (c - 1) % 4 == 0);
         step();
      end
      chk("tri_pinc@33", pinc[2], 16'h1200);
      chk("saw_pinc@33", pinc[3], 16'h1000);

      // Abort the triangle while it holds 0x1200.
      stop_v[2] = 1'b1;
      step();
      stop_v[2] = 1'b0;
      chk("stop_run", run[2], 1'b0);
      chk("stop_pinc", pinc[2], 16'h1200);
      chk("stop_cfg", cfg[2], 1'b0);
      chk("stop_done", done[2], 1'b0);
      for (int c = 35; c <= 41; c++) step();
      chk("stop_hold_pinc", pinc[2], 16'h1200);
      chk("stop_hold_run", run[2], 1'b0);
      chk("saw_pinc@41", pinc[3], 16'h1200);
      chk("saw_cfg@41", cfg[3], 1'b1);

      // Restart the saw mid-sweep.
      start_v[3] = 1'b1;
      step();
      start_v[3] = 1'b0;
      chk("restart_pinc", pinc[3], 16'h1000);
      chk("restart_cfg", cfg[3], 1'b1);
      chk("restart_run", run[3], 1'b1);
      for (int c = 1; c <= 3; c++) begin
         step();
         chk($sformatf("restart_hold_cfg%0d", c), cfg[3], 1'b0);
         chk($sformatf("restart_hold_pinc%0d", c), pinc[3], 16'h1000);
      end
      step();
      chk("restart_next_pinc", pinc[3], 16'h1100);
      chk("restart_next_cfg", cfg[3], 1'b1);

      // Simultaneous start and stop: stop wins, both in DWELL and in IDLE.
      start_v[3] = 1'b1; stop_v[3] = 1'b1;
      start_v[2] = 1'b1; stop_v[2] = 1'b1;
      step();
      start_v[3] = 1'b0; stop_v[3] = 1'b0;
      start_v[2] = 1'b0; stop_v[2] = 1'b0;
      chk("both_run", run[3], 1'b0);
      chk("both_cfg", cfg[3], 1'b0);
      chk("both_pinc", pinc[3], 16'h1100);
      chk("both_idle_run", run[2], 1'b0);
      chk("both_idle_cfg", cfg[2], 1'b0);

      // Asynchronous reset in the middle of a dwell.
      start_v[0] = 1'b1;
      step();
      start_v[0] = 1'b0;
      for (int c = 2; c <= 6; c++) step();
      chk("pre_rst_pinc", pinc[0], 16'h1100);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_pinc", pinc[0], 16'h1000);
      chk("arst_cfg", cfg[0], 1'b0);
      chk("arst_run", run[0], 1'b0);
      chk("arst_done", done[0], 1'b0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         chk($sformatf("post_rst_run%0d", c), run[0], 1'b0);
         chk($sformatf("post_rst_cfg%0d", c), cfg[0], 1'b0);
      end
      start_v[0] = 1'b1;
      step();
      start_v[0] = 1'b0;
      chk("rerun_pinc", pinc[0], 16'h1000);
      chk("rerun_cfg", cfg[0], 1'b1);
      for (int c = 2; c <= 5; c++) step();
      chk("rerun_next_pinc", pinc[0], 16'h1100);
      chk("rerun_next_cfg", cfg[0], 1'b1);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
